// File: rtl/display_pkg.sv
// Shared display definitions: FSM states, seven-segment glyphs and the
// representable range of a 4-digit signed display.
package display_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_ENCODE
    } state_t;

    localparam int DIGITS = 4;

    // Segment bit order: bit 0 = a ... bit 6 = g, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_R     = 7'h50;

    // Largest positive value (9999) and largest negative magnitude (-999),
    // both held as 17-bit magnitudes so -32768 compares without wrapping.
    localparam logic [16:0] RANGE_POS_MAX = 17'd9999;
    localparam logic [16:0] RANGE_NEG_MAX = 17'd999;

    localparam logic [3:0] LAST_ITER = 4'd13;

endpackage

// File: rtl/bin_to_segments_if.sv
// Request/result bundle between the calculator side and bin_to_segments.
interface bin_to_segments_if;
    import display_pkg::*;

    // Handshake: start is a one-cycle request honoured only while busy is low
    // and enable is high; done pulses once for the cycle the results update.
    logic        enable;
    logic        start;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        negative;
    logic [15:0] bcd_out;
    logic [31:0] segment_data;
    state_t      state;

    modport master (
        output enable, start, value,
        input  busy, done, overflow, negative, bcd_out, segment_data, state
    );

    modport slave (
        input  enable, start, value,
        output busy, done, overflow, negative, bcd_out, segment_data, state
    );

endinterface

// File: rtl/seg7_encode.sv
// One BCD digit to seven segments; non-decimal codes and blanked digits are dark.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin_to_segments.sv
// Signed 16-bit value to 4-digit seven-segment word via sequential
// double-dabble, with leading-zero blanking, minus sign and "Err".
module bin_to_segments
    import display_pkg::*;
#(
    parameter bit         LZ_BLANK = 1'b1,
    parameter logic [3:0] DP_MASK  = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_segments_if.slave bus
);

    state_t      state;
    state_t      state_next;

    logic [15:0] val_q;
    logic [13:0] mag_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        neg_q;
    logic        ovf_q;

    logic        done_q;
    logic        overflow_q;
    logic        negative_q;
    logic [15:0] bcd_out_q;
    logic [31:0] seg_q;

    logic [16:0] val_ext;
    logic [16:0] mag17;
    logic        out_of_range;
    logic [15:0] bcd_adj;
    logic [3:0]  blank;
    logic [6:0]  seg_digit [DIGITS];
    logic [31:0] seg_word;

    assign val_ext      = {val_q[15], val_q};
    assign mag17        = val_q[15] ? (17'd0 - val_ext) : val_ext;
    assign out_of_range = val_q[15] ? (mag17 > RANGE_NEG_MAX) : (mag17 > RANGE_POS_MAX);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A digit goes dark only when it and every digit above it are zero.
    assign blank[3] = LZ_BLANK && (bcd_q[15:12] == 4'd0);
    assign blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    assign blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    assign blank[0] = 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_encode u_enc (
            .bcd   (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_digit[g])
        );
    end

    always_comb begin
        seg_word = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_word[8*i +: 8] = {DP_MASK[i], seg_digit[i]};
        end
        if (neg_q) begin
            seg_word[31:24] = {DP_MASK[3], SEG_MINUS};
        end
        if (ovf_q) begin
            seg_word = {1'b0, SEG_E, 1'b0, SEG_R, 1'b0, SEG_R, 1'b0, SEG_BLANK};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.start) state_next = S_CHECK;
            S_CHECK:  state_next = out_of_range ? S_ENCODE : S_SHIFT;
            S_SHIFT:  if (cnt_q == LAST_ITER) state_next = S_ENCODE;
            S_ENCODE: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else if (bus.enable) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q      <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
            bcd_out_q  <= '0;
            seg_q      <= '0;
        end else if (bus.enable) begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) val_q <= bus.value;
                end
                S_CHECK: begin
                    neg_q <= val_q[15];
                    ovf_q <= out_of_range;
                    mag_q <= mag17[13:0];
                    bcd_q <= '0;
                    cnt_q <= '0;
                end
                S_SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cnt_q          <= cnt_q + 4'd1;
                end
                S_ENCODE: begin
                    done_q     <= 1'b1;
                    overflow_q <= ovf_q;
                    negative_q <= neg_q & ~ovf_q;
                    bcd_out_q  <= ovf_q ? 16'd0 : bcd_q;
                    seg_q      <= seg_word;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = done_q;
    assign bus.overflow     = overflow_q;
    assign bus.negative     = negative_q;
    assign bus.bcd_out      = bcd_out_q;
    assign bus.segment_data = seg_q;
    assign bus.state        = state;

endmodule

// File: tb/tb_bin_to_segments.sv
// Bench for bin_to_segments: three instances (default, no blanking, dp mask)
// driven in lockstep and compared with an arithmetic reference model.
module tb_bin_to_segments;
    import display_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        st;
    logic [15:0] val;

    int n_checks = 0;
    int n_errors = 0;

    bin_to_segments_if if_a ();
    bin_to_segments_if if_b ();
    bin_to_segments_if if_c ();

    assign if_a.enable = en;
    assign if_a.start  = st;
    assign if_a.value  = val;
    assign if_b.enable = en;
    assign if_b.start  = st;
    assign if_b.value  = val;
    assign if_c.enable = en;
    assign if_c.start  = st;
    assign if_c.value  = val;

    bin_to_segments #(.LZ_BLANK(1'b1), .DP_MASK(4'b0000)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    bin_to_segments #(.LZ_BLANK(1'b0), .DP_MASK(4'b0000)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    bin_to_segments #(.LZ_BLANK(1'b1), .DP_MASK(4'b1010)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        ovf;
        logic        neg;
        logic [15:0] bcd;
        logic [31:0] seg;
    } res_t;

    function automatic res_t model(int v, bit lz, logic [3:0] dp);
        logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        res_t r;
        int   mag;
        int   p;
        int   d;
        logic [7:0] b;
        r.ovf = 1'b0;
        r.neg = 1'b0;
        r.bcd = '0;
        r.seg = '0;
        if (v > 9999 || v < -999) begin
            r.ovf = 1'b1;
            r.seg = 32'h79505000;
            return r;
        end
        r.neg = (v < 0);
        mag   = r.neg ? -v : v;
        p     = 1;
        for (int i = 0; i < 4; i++) begin
            d = (mag / p) % 10;
            r.bcd[4*i +: 4] = 4'(d);
            if (r.neg && i == 3)             b = 8'h40;
            else if (lz && i > 0 && mag < p) b = 8'h00;
            else                             b = tbl[d];
            b[7] = b[7] | dp[i];
            r.seg[8*i +: 8] = b;
            p = p * 10;
        end
        return r;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_dut(string tag, int v);
        res_t ra, rb, rc;
        ra = model(v, 1'b1, 4'b0000);
        rb = model(v, 1'b0, 4'b0000);
        rc = model(v, 1'b1, 4'b1010);
        chk({tag, "_seg_a"}, if_a.segment_data, ra.seg);
        chk({tag, "_bcd_a"}, {16'd0, if_a.bcd_out}, {16'd0, ra.bcd});
        chk({tag, "_ovf_a"}, {31'd0, if_a.overflow}, {31'd0, ra.ovf});
        chk({tag, "_neg_a"}, {31'd0, if_a.negative}, {31'd0, ra.neg});
        chk({tag, "_seg_b"}, if_b.segment_data, rb.seg);
        chk({tag, "_bcd_b"}, {16'd0, if_b.bcd_out}, {16'd0, rb.bcd});
        chk({tag, "_seg_c"}, if_c.segment_data, rc.seg);
    endtask

    // Pulse start with value v, wait for done and check latency and busy.
    task automatic convert(string tag, int v, int exp_lat);
        int n;
        bit busy_ok;
        val = 16'(v);
        st  = 1'b1;
        step();
        st = 1'b0;
        chk({tag, "_busy_start"}, {31'd0, if_a.busy}, 32'd1);
        n       = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            n = k;
            if (if_a.done) break;
            if (!if_a.busy) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, if_a.busy}, 32'd0);
        chk({tag, "_done_bc"}, {30'd0, if_b.done, if_c.done}, 32'd3);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        int          v;
        logic [31:0] seg_a;
        logic [31:0] seg_b;
        logic [15:0] bcd;
        bit          ovf;
        bit          neg;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int n;
        int dones;
        int v;
        logic [15:0] tmp16;

        vecs[0]  = '{1234,   32'h065B4F66, 32'h065B4F66, 16'h1234, 1'b0, 1'b0};
        vecs[1]  = '{7,      32'h00000007, 32'h3F3F3F07, 16'h0007, 1'b0, 1'b0};
        vecs[2]  = '{0,      32'h0000003F, 32'h3F3F3F3F, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{-42,    32'h4000665B, 32'h403F665B, 16'h0042, 1'b0, 1'b1};
        vecs[4]  = '{10000,  32'h79505000, 32'h79505000, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{-1000,  32'h79505000, 32'h79505000, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{-32768, 32'h79505000, 32'h79505000, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{32767,  32'h79505000, 32'h79505000, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{9999,   32'h6F6F6F6F, 32'h6F6F6F6F, 16'h9999, 1'b0, 1'b0};
        vecs[9]  = '{-999,   32'h406F6F6F, 32'h406F6F6F, 16'h0999, 1'b0, 1'b1};
        vecs[10] = '{-1,     32'h40000006, 32'h403F3F06, 16'h0001, 1'b0, 1'b1};
        vecs[11] = '{100,    32'h00063F3F, 32'h3F063F3F, 16'h0100, 1'b0, 1'b0};
        vecs[12] = '{10,     32'h0000063F, 32'h3F3F063F, 16'h0010, 1'b0, 1'b0};
        vecs[13] = '{-10,    32'h4000063F, 32'h403F063F, 16'h0010, 1'b0, 1'b1};

        rst = 1'b0;
        en  = 1'b1;
        st  = 1'b0;
        val = '0;
        repeat (3) step();

        chk("rst_busy", {31'd0, if_a.busy}, 32'd0);
        chk("rst_done", {29'd0, if_a.done, if_b.done, if_c.done}, 32'd0);
        chk("rst_flags", {30'd0, if_a.overflow, if_a.negative}, 32'd0);
        chk("rst_bcd", {16'd0, if_a.bcd_out}, 32'd0);
        chk("rst_seg_a", if_a.segment_data, 32'd0);
        chk("rst_seg_b", if_b.segment_data, 32'd0);
        chk("rst_seg_c", if_c.segment_data, 32'd0);
        chk("rst_state", {30'd0, if_a.state}, {30'd0, S_IDLE});

        rst = 1'b1;
        step();

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            convert($sformatf("vec%0d", i), vecs[i].v, vecs[i].ovf ? 2 : 16);
            chk($sformatf("vec%0d_seg_a_tbl", i), if_a.segment_data, vecs[i].seg_a);
            chk($sformatf("vec%0d_seg_b_tbl", i), if_b.segment_data, vecs[i].seg_b);
            chk($sformatf("vec%0d_bcd_tbl", i), {16'd0, if_a.bcd_out}, {16'd0, vecs[i].bcd});
            chk($sformatf("vec%0d_flags_tbl", i), {30'd0, if_a.overflow, if_a.negative},
                {30'd0, vecs[i].ovf, vecs[i].neg});
            check_dut($sformatf("vec%0d", i), vecs[i].v);
            step();
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, if_a.done}, 32'd0);
        end

        // Randomized values against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       v = int'($urandom_range(0, 9999));
                1:       v = -int'($urandom_range(1, 999));
                default: begin
                    tmp16 = 16'($urandom_range(0, 65535));
                    v     = int'($signed(tmp16));
                end
            endcase
            convert($sformatf("rnd%0d", i), v, (v > 9999 || v < -999) ? 2 : 16);
            check_dut($sformatf("rnd%0d", i), v);
            repeat ($urandom_range(0, 2)) step();
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        val = 16'd1234;
        st  = 1'b1;
        step();
        st    = 1'b0;
        n     = -1;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                val = 16'd555;
                st  = 1'b1;
            end
            step();
            st = 1'b0;
            if (if_a.done) begin
                dones++;
                n = k;
                break;
            end
        end
        chk("ign_latency", n, 16);
        chk("ign_dones", dones, 1);
        check_dut("ign", 1234);

        val = 16'hFFD6;
        st  = 1'b1;
        step();
        st = 1'b0;
        chk("bb_done_pulse", {31'd0, if_a.done}, 32'd0);
        chk("bb_busy", {31'd0, if_a.busy}, 32'd1);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (if_a.done) begin
                n = k;
                break;
            end
        end
        chk("bb_latency", n, 16);
        check_dut("bb", -42);
        step();

        // Reset during the shift phase.
        val = 16'd1234;
        st  = 1'b1;
        step();
        st = 1'b0;
        repeat (9) step();
        chk("mid_busy_pre", {31'd0, if_a.busy}, 32'd1);
        rst = 1'b0;
        step();
        chk("mid_busy", {31'd0, if_a.busy}, 32'd0);
        chk("mid_seg", if_a.segment_data, 32'd0);
        chk("mid_done", {31'd0, if_a.done}, 32'd0);
        chk("mid_bcd", {16'd0, if_a.bcd_out}, 32'd0);
        chk("mid_neg", {31'd0, if_a.negative}, 32'd0);
        rst   = 1'b1;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (if_a.done) dones++;
        end
        chk("mid_no_done", dones, 0);

        // Enable low for three cycles mid-shift stretches latency to 19.
        val = 16'(-999);
        st  = 1'b1;
        step();
        st = 1'b0;
        n  = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 7)  en = 1'b0;
            if (k == 10) en = 1'b1;
            step();
            if (if_a.done) begin
                n = k;
                break;
            end
        end
        chk("en_latency", n, 19);
        check_dut("en", -999);

        // done stays high across disabled edges.
        en = 1'b0;
        step();
        step();
        chk("en_done_held", {31'd0, if_a.done}, 32'd1);
        en = 1'b1;
        step();
        chk("en_done_clear", {31'd0, if_a.done}, 32'd0);
        chk("en_hold_seg", if_a.segment_data, 32'h406F6F6F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
